// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: multi-cycle multiply/divide step sequencer for the decode stage.
//
// Tracks how many cycles the MUL/DIV instruction held in ID has issued and
// produces the per-step control bits that ID registers into EXE, plus a hold
// request to the hazard unit.
//
// Parameters:
//   MUL_CYCLES  issue cycles per multiply (>= 1)
//   DIV_CYCLES  issue cycles per divide, including the final cycle (>= 2)
//   CNT_W       step counter width, 2**CNT_W >= max(MUL_CYCLES, DIV_CYCLES)
//
// Ports:
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   enable       ID stage advance (low = stalled from downstream)
//   flush_i      pipeline flush, aborts any operation in progress
//   is_m_i       ID holds a MUL/MULH/MULHSU/MULHU
//   is_d_i       ID holds a DIV/DIVU/REM/REMU
//   mul_state_o  current multiply step, 0 when not multiplying
//   div_state_o  current divide step, 0 when not dividing
//   d_init_o     divide step 0
//   d_advance_o  divide steps 1..DIV_CYCLES-1
//   div_last_o   divide step DIV_CYCLES-1
//   fin_o        final step of the current MUL or DIV
//   busy_o       hold IF/ID, more steps remain

module md_seq_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 17,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             flush_i,
    input  logic             is_m_i,
    input  logic             is_d_i,
    output logic [CNT_W-1:0] mul_state_o,
    output logic [CNT_W-1:0] div_state_o,
    output logic             d_init_o,
    output logic             d_advance_o,
    output logic             div_last_o,
    output logic             fin_o,
    output logic             busy_o
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    if (MUL_CYCLES < 1) begin : g_bad_mul
        $error("md_seq_ctrl: MUL_CYCLES must be >= 1");
    end
    if (DIV_CYCLES < 2) begin : g_bad_div
        $error("md_seq_ctrl: DIV_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) < 64'(MaxCycles)) begin : g_bad_cnt_w
        $error("md_seq_ctrl: CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] MulLast = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    // A single-cycle multiply completes in IDLE and never enters MUL.
    localparam bit               MulOne  = (MUL_CYCLES == 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_state_o = '0;
        div_state_o = '0;
        d_init_o    = 1'b0;
        d_advance_o = 1'b0;
        div_last_o  = 1'b0;
        fin_o       = 1'b0;
        busy_o      = 1'b0;

        if (flush_i) begin
            // Flush silences all outputs and wins over a stall.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_d_i) begin
                        d_init_o = 1'b1;
                        busy_o   = 1'b1;
                        if (enable) begin
                            state_d = StDiv;
                            cnt_d   = CntOne;
                        end
                    end else if (is_m_i) begin
                        fin_o  = MulOne;
                        busy_o = !MulOne;
                        if (enable && !MulOne) begin
                            state_d = StMul;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StMul: begin
                    if (!is_m_i) begin
                        // Operation dropped: outputs stay 0, no fin.
                        if (enable) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        mul_state_o = cnt_q;
                        if (cnt_q == MulLast) begin
                            fin_o = 1'b1;
                            if (enable) begin
                                state_d = StIdle;
                                cnt_d   = '0;
                            end
                        end else begin
                            busy_o = 1'b1;
                            if (enable) begin
                                cnt_d = cnt_q + CntOne;
                            end
                        end
                    end
                end
                StDiv: begin
                    if (!is_d_i) begin
                        if (enable) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        div_state_o = cnt_q;
                        d_advance_o = 1'b1;
                        if (cnt_q == DivLast) begin
                            div_last_o = 1'b1;
                            fin_o      = 1'b1;
                            if (enable) begin
                                state_d = StIdle;
                                cnt_d   = '0;
                            end
                        end else begin
                            busy_o = 1'b1;
                            if (enable) begin
                                cnt_d = cnt_q + CntOne;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/md_seq_ctrl.md
# md_seq_ctrl

Parametrised multi-cycle multiply/divide sequencer for the decode stage. It tracks how many cycles the MUL/DIV instruction held in ID has issued. It generates the per-step control bits (`mul_state`, `d_init`, `d_advance`, `div_last`, `fin`) that ID registers into EXE, plus a `busy_o` hold request to the hazard unit. It replaces the fixed 4-step multiply and 16+1-step divide counters with configurable latencies, and adds explicit flush abort, stall freeze and operation-drop recovery.

## Interface
- `MUL_CYCLES`, default 4: issue cycles per multiply. Legal range ≥1.
- `DIV_CYCLES`, default 17: issue cycles per divide, including the final cycle. Legal range ≥2.
- `CNT_W`, default 5: step counter width. Must satisfy 2^CNT_W ≥ max(MUL_CYCLES, DIV_CYCLES). Elaboration error otherwise.
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, asynchronous assert, active-low.
- `enable`  in  1: ID stage advance. Low means stalled from downstream.
- `flush_i`  in  1: pipeline flush. Aborts any operation in progress.
- `is_m_i`  in  1: decoded instruction in ID is MUL/MULH/MULHSU/MULHU.
- `is_d_i`  in  1: decoded instruction in ID is DIV/DIVU/REM/REMU.
- `mul_state_o`  out  CNT_W: current multiply step index. 0 when not multiplying.
- `div_state_o`  out  CNT_W: current divide step index. 0 when not dividing.
- `d_init_o`  out  1: divide step 0.
- `d_advance_o`  out  1: divide step 1..DIV_CYCLES-1.
- `div_last_o`  out  1: divide step DIV_CYCLES-1.
- `fin_o`  out  1: final step of the current MUL or DIV.
- `busy_o`  out  1: hold IF/ID this cycle, because more steps remain.

## Operation
- **State:** FSM states are IDLE, MUL and DIV, plus a step counter `cnt[CNT_W-1:0]`.
- **Step index:** the current step is 0 in IDLE and `cnt` in MUL/DIV. All outputs are combinational from state, `cnt`, `is_m_i`, `is_d_i` and `flush_i`, so ID captures them in the same cycle as the instruction fields.
- **IDLE:**
  - If `is_d_i`, this is divide step 0: `d_init_o`=1 and `div_state_o`=0.
  - Else if `is_m_i`, this is multiply step 0: `mul_state_o`=0.
  - Divide wins if both inputs are high.
  - On an enabled edge, go to MUL/DIV with `cnt`=1. Exception: if MUL_CYCLES=1, `fin_o` is asserted in IDLE and the FSM stays in IDLE.
- **MUL:**
  - `mul_state_o`=`cnt`.
  - If `cnt`==MUL_CYCLES-1: `fin_o`=1, `busy_o`=0, and the next state is IDLE with `cnt`=0.
  - Otherwise `busy_o`=1 and `cnt`++.
- **DIV:**
  - `div_state_o`=`cnt` and `d_advance_o`=1.
  - If `cnt`==DIV_CYCLES-1: `div_last_o`=1, `fin_o`=1, `busy_o`=0, and the next state is IDLE.
  - Otherwise `busy_o`=1 and `cnt`++.
- **busy_o in IDLE:** equals (`is_d_i` | (`is_m_i` & MUL_CYCLES>1)) & ~`flush_i`.
- **Stall:** while `enable`=0, state and `cnt` hold and outputs stay steady. A stall never advances a step.
- **Flush:** `flush_i`=1 forces every output to 0 in that cycle. On the edge the FSM goes to IDLE with `cnt`=0. Flush has priority over `enable`.
- **Operation dropped:** if in MUL with `is_m_i`=0, or in DIV with `is_d_i`=0, while enabled:
  - all outputs are 0;
  - the FSM returns to IDLE;
  - `fin_o` is not raised.
- **Back-to-back:** a new MUL/DIV arriving on the cycle after `fin_o` starts at step 0. There is no bubble.
- **Counter wrap:** `cnt` never exceeds the op's cycle count minus 1. Wrap is unreachable by the parameter rule.

## Timing
- **Reset:** while `resetn`=0, state=IDLE and `cnt`=0 immediately (asynchronous). With `is_*_i` low, all outputs are 0.
- **Latency:**
  - A MUL occupies exactly MUL_CYCLES enabled cycles in ID. `busy_o` is high for the first MUL_CYCLES-1 of them; `fin_o` is high on the last.
  - A DIV occupies DIV_CYCLES enabled cycles, with `d_init_o` on cycle 1 and `div_last_o`/`fin_o` on cycle DIV_CYCLES.
- **Stalls:** N stall cycles add exactly N cycles. `fin_o` stays high across a stall on the last step.
- **Reset mid-op:** returns to IDLE asynchronously. No partial `fin_o`.

## Test plan
- **Reset:** assert `resetn`=0 mid-DIV at step 7, with `is_d_i` held -> state is IDLE; after release `d_init_o`=1 and `div_state_o`=0.
- **Default MUL:** `is_m_i`=1 for 4 cycles, `enable`=1 -> `mul_state_o`=0,1,2,3; `busy_o`=1,1,1,0; `fin_o`=0,0,0,1.
- **Default DIV:** `is_d_i`=1 for 17 cycles -> `d_init_o` on cycle 1 only; `d_advance_o` on cycles 2–17; `div_last_o`/`fin_o` on cycle 17 only; `div_state_o`=16 at the end.
- **Stall and flush:** MUL with `enable`=0 for 3 cycles at step 2 -> `mul_state_o` holds 2 and completion moves out by 3 cycles. DIV flushed at step 5 -> all outputs 0 that cycle; the next DIV restarts at `d_init_o`.
- **Parametric:** MUL_CYCLES=1, DIV_CYCLES=2 -> MUL gives `fin_o`=1 in a single cycle with `busy_o`=0; DIV gives `d_init_o` then `div_last_o`+`fin_o`. MUL→DIV back-to-back -> DIV step 0 on the cycle immediately after the MUL's `fin_o`.
- **Edge cases:** `is_m_i`=`is_d_i`=1 in IDLE -> the divide sequence runs. `is_d_i` dropped at step 3 -> outputs 0, IDLE, and no `fin_o`.
